// File: rtl/npc_mem_arbiter_if.sv
// Bundled IFU, LSU and memory-side signals of the npc memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface npc_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_resp_valid;
    logic [31:0]       if_rdata;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_wen;
    logic [DATA_W-1:0] ls_wdata;
    logic [7:0]        ls_wmask;
    logic              ls_resp_valid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              err;

    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output busy, err
    );

    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  busy, err
    );
endinterface

// File: rtl/npc_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one outstanding
// transaction at a time, returning each response to its issuer with a response timeout.
module npc_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    npc_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic        OWNER_IF = 1'b0;
    localparam logic        OWNER_LS = 1'b1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    // owner also serves as last_grant: both are only ever updated together on a grant
    logic              owner;
    logic              grant_if;
    logic              grant_ls;
    logic [15:0]       wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (grant_if || grant_ls) next_state = S_REQ;
            S_REQ:   if (bus.mem_req_ready) next_state = S_WAIT;
            S_WAIT:  if (bus.mem_resp_valid || wait_cnt == CNT_LAST) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // On a conflict the requester that did not win last time gets the port.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (rst && state == S_IDLE) begin
            if (bus.if_req_valid && bus.ls_req_valid) begin
                grant_if = (owner == OWNER_LS);
                grant_ls = (owner == OWNER_IF);
            end else begin
                grant_if = bus.if_req_valid;
                grant_ls = bus.ls_req_valid;
            end
        end
        bus.if_req_ready  = grant_if;
        bus.ls_req_ready  = grant_ls;
        bus.mem_req_valid = (state == S_REQ);
        bus.busy          = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner             <= OWNER_IF;
            addr_q            <= '0;
            wen_q             <= 1'b0;
            wdata_q           <= '0;
            wmask_q           <= 8'h00;
            wait_cnt          <= 16'd0;
            bus.if_resp_valid <= 1'b0;
            bus.if_rdata      <= 32'h0;
            bus.ls_resp_valid <= 1'b0;
            bus.ls_rdata      <= '0;
            bus.err           <= 1'b0;
        end else begin
            bus.if_resp_valid <= 1'b0;
            bus.ls_resp_valid <= 1'b0;
            bus.err           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_if) begin
                        owner   <= OWNER_IF;
                        addr_q  <= bus.if_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= 8'h00;
                    end else if (grant_ls) begin
                        owner   <= OWNER_LS;
                        addr_q  <= bus.ls_addr;
                        wen_q   <= bus.ls_wen;
                        wdata_q <= bus.ls_wdata;
                        wmask_q <= bus.ls_wen ? bus.ls_wmask : 8'h00;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) wait_cnt <= 16'd0;
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (owner == OWNER_LS) begin
                            bus.ls_resp_valid <= 1'b1;
                            bus.ls_rdata      <= bus.mem_rdata;
                        end else begin
                            bus.if_resp_valid <= 1'b1;
                            bus.if_rdata      <= addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        bus.err <= 1'b1;
                        if (owner == OWNER_LS) begin
                            bus.ls_resp_valid <= 1'b1;
                            bus.ls_rdata      <= '0;
                        end else begin
                            bus.if_resp_valid <= 1'b1;
                            bus.if_rdata      <= 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
endmodule

// File: doc/npc_mem_arbiter.md
Name: npc_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch unit and the load/store unit of the npc core.
- Sequences single-outstanding transactions through a 3-state FSM and returns each response to its issuer.
- Guards against a hung memory with a response timeout.
- Sits between IFU/LSU and the memory model.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory data width; fixed at 64, since the instruction slice selection depends on it.
- TIMEOUT, 255, maximum cycles spent in WAIT before error; legal range 1..65535.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_req_valid  in  1  IFU fetch request.
- if_req_ready  out  1  IFU request accepted this cycle.
- if_addr  in  ADDR_W  fetch address; 4-byte aligned.
- if_resp_valid  out  1  fetch data valid; one-cycle pulse.
- if_rdata  out  32  fetched instruction.
- ls_req_valid  in  1  LSU request.
- ls_req_ready  out  1  LSU request accepted this cycle.
- ls_addr  in  ADDR_W  load/store address.
- ls_wen  in  1  1 = store, 0 = load.
- ls_wdata  in  DATA_W  store data.
- ls_wmask  in  8  store byte mask.
- ls_resp_valid  out  1  load data / store done; one-cycle pulse.
- ls_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  latched address.
- mem_wen  out  1  latched write enable.
- mem_wdata  out  DATA_W  latched write data.
- mem_wmask  out  8  latched mask; 0 for reads.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.
- err  out  1  timeout pulse, coincident with the failing resp_valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; owner=IFU; last_grant=IFU.
  - Timeout counter = 0; all latched request registers = 0.
  - All outputs = 0.
  - Any in-flight transaction is dropped.
  - mem_resp_valid seen while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Exactly one ready may be high, combinationally, for the granted valid requester.
  - Only IFU valid: grant IFU. Only LSU valid: grant LSU.
  - Both valid: grant the requester that is not last_grant. After reset the first conflict therefore goes to LSU.
  - On grant, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and owner, update last_grant, then go to REQ.
  - No grant: stay in IDLE.
- REQ:
  - mem_req_valid=1 with the latched fields held stable.
  - mem_req_ready=1: go to WAIT and clear the counter.
  - Otherwise hold in REQ indefinitely; no timeout applies in REQ.
- WAIT:
  - mem_req_valid=0; the counter increments each cycle.
  - mem_resp_valid=1:
    - Next cycle the owner's resp_valid=1 for one cycle and rdata is registered.
    - IFU: if_rdata = latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
    - LSU: ls_rdata = mem_rdata; for stores ls_rdata is don't-care.
    - FSM returns to IDLE.
  - Counter reaches TIMEOUT with no response:
    - Next cycle the owner's resp_valid=1, rdata=0, err=1, and the FSM returns to IDLE.
    - A later stray mem_resp_valid is ignored.
- Memory must not respond in the same cycle as the mem_req_ready handshake.
- Latency: grant in cycle N, mem_req_valid in N+1. With ready in N+1, the earliest response is N+2 and resp_valid is N+3.
- New grants are possible in the cycle resp_valid is high, because the FSM is already in IDLE.
- Non-owner resp_valid stays 0 at all times.
- busy = (state != IDLE).
- Requesters must hold valid and payload stable until ready; the block samples them only on grant.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: LSU load granted, memory stalls; drive rst=0 for 1 cycle.
  - Response: busy=0 and all outputs 0 immediately; a later mem_resp_valid produces no resp_valid.
- Single IFU fetch:
  - Stimulus: if_addr=0x80000004, mem_rdata=0x00100073_00000413, memory ready and response with zero wait.
  - Response: if_req_ready in cycle 0, mem_req_valid in cycle 1, if_resp_valid in cycle 3, if_rdata=0x00100073.
- Simultaneous requests after reset:
  - Stimulus: both valid in three consecutive transactions.
  - Response: grant order LSU, IFU, LSU; never both readies high in the same cycle.
- LSU store with backpressure:
  - Stimulus: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F; mem_req_ready low for 5 cycles.
  - Response: mem fields stable for 6 cycles; no err; ls_resp_valid one cycle after mem_resp_valid.
- Timeout:
  - Stimulus: TIMEOUT=4; the memory never responds.
  - Response: exactly 4 WAIT cycles, then ls_resp_valid=1, err=1, ls_rdata=0; FSM back in IDLE. A late mem_resp_valid is ignored.
- Back-to-back fetches:
  - Stimulus: IFU valid held continuously, memory with zero wait.
  - Response: one grant every 3 cycles (IDLE/REQ/WAIT); if_rdata alternates halves for addresses 0x0 and 0x4.
